// File: rtl/musicbox_pkg.sv
// Shared types, sizes and the song tables for the music-box note sequencer.
package musicbox_pkg;

  localparam int SONG_COUNT = 4;
  localparam int SONG_LEN   = 64;
  localparam int FREQ_W     = 14;
  localparam int DUR_W      = 10;
  localparam int SONG_W     = 2;
  localparam int IDX_W      = 6;
  localparam int ROM_AW     = SONG_W + IDX_W;
  localparam int ROM_DEPTH  = SONG_COUNT * SONG_LEN;
  localparam int TICK_W     = 26;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [DUR_W-1:0]  dur;
  } note_entry_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    PLAY  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  function automatic note_entry_t mk_note(input int freq_hz, input int dur_units);
    note_entry_t e;
    e.freq = FREQ_W'(freq_hz);
    e.dur  = DUR_W'(dur_units);
    return e;
  endfunction

  // A zero duration marks the end of a song; unused slots are all end markers.
  function automatic note_entry_t song_entry(input logic [SONG_W-1:0] song,
                                             input logic [IDX_W-1:0]  idx);
    note_entry_t e;
    e = '0;
    case (song)
      2'd0: begin
        if (idx == 6'd0) e = mk_note(440, 2);
      end
      2'd1: begin
        case (idx)
          6'd0:    e = mk_note(523, 1);
          6'd1:    e = mk_note(0, 1);
          6'd2:    e = mk_note(659, 1);
          default: e = '0;
        endcase
      end
      2'd2: begin
        e = mk_note(200 + 10 * int'(idx), 1);
      end
      default: begin
        case (idx)
          6'd0:    e = mk_note(330, 1);
          6'd1:    e = mk_note(392, 1);
          default: e = '0;
        endcase
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/note_rom.sv
// Song table ROM: address {song, index}, one cycle registered read latency.
module note_rom
  import musicbox_pkg::*;
(
  input  logic              CLK_32KHz,
  input  logic [ROM_AW-1:0] addr,
  output note_entry_t       data
);

  note_entry_t rom_table [ROM_DEPTH];
  note_entry_t data_reg;

  for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
    assign rom_table[gi] = song_entry(SONG_W'(gi / SONG_LEN), IDX_W'(gi % SONG_LEN));
  end

  always_ff @(posedge CLK_32KHz) begin
    data_reg <= rom_table[addr];
  end

  assign data = data_reg;

endmodule

// File: rtl/note_sequencer.sv
// Plays songs from note_rom as frequency/amplitude pairs for a signal generator.
// Build option: define NOTE_SEQ_LOOP_EN to restart a song at its end instead of stopping.
module note_sequencer
  import musicbox_pkg::*;
#(
  parameter logic [7:0] AMP_ON         = 8'd200,
  parameter int         TICKS_PER_UNIT = 32,
  parameter int         GAP_TICKS      = 320
) (
  input  logic              CLK_32KHz,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [SONG_W-1:0] songSelect,
  output logic [FREQ_W-1:0] outputFrequency,
  output logic [7:0]        outputAmplitude,
  output logic [IDX_W-1:0]  noteIndex,
  output logic              busy,
  output logic              songDone
);

  localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_TICKS - 1);
  localparam logic [TICK_W-1:0] TPU       = TICK_W'(TICKS_PER_UNIT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SONG_LEN - 1);

  seq_state_t        state_reg, state_next;
  logic [SONG_W-1:0] song_reg, song_next;
  logic [IDX_W-1:0]  index_reg, index_next;
  logic [TICK_W-1:0] tick_reg, tick_next;
  logic [FREQ_W-1:0] freq_reg, freq_next;
  logic [7:0]        amp_reg, amp_next;
  logic              done_reg, done_next;
  logic              end_hit;
  logic [TICK_W-1:0] play_ticks;
  logic [ROM_AW-1:0] rom_addr;
  note_entry_t       rom_data;

  // Address comes from next-state values so the entry is ready during FETCH.
  assign rom_addr = {song_next, index_next};

  note_rom u_rom (
    .CLK_32KHz (CLK_32KHz),
    .addr      (rom_addr),
    .data      (rom_data)
  );

  assign play_ticks = TICK_W'(rom_data.dur) * TPU;

  always_ff @(posedge CLK_32KHz or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      song_reg  <= '0;
      index_reg <= '0;
      tick_reg  <= '0;
      freq_reg  <= '0;
      amp_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      song_reg  <= song_next;
      index_reg <= index_next;
      tick_reg  <= tick_next;
      freq_reg  <= freq_next;
      amp_reg   <= amp_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    song_next  = song_reg;
    index_next = index_reg;
    tick_next  = tick_reg;
    freq_next  = freq_reg;
    amp_next   = 8'd0;
    done_next  = 1'b0;
    end_hit    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          song_next  = songSelect;
          index_next = '0;
          tick_next  = '0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (rom_data.dur == '0) begin
          end_hit = 1'b1;
        end else begin
          freq_next  = rom_data.freq;
          amp_next   = (rom_data.freq == '0) ? 8'd0 : AMP_ON;
          tick_next  = play_ticks - TICK_W'(1);
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (tick_reg == '0) begin
          tick_next  = GAP_LAST;
          state_next = GAP;
        end else begin
          tick_next = tick_reg - TICK_W'(1);
          amp_next  = amp_reg;
        end
      end
      GAP: begin
        if (tick_reg == '0) begin
          if (index_reg == LAST_IDX) begin
            end_hit = 1'b1;
          end else begin
            index_next = index_reg + IDX_W'(1);
            state_next = FETCH;
          end
        end else begin
          tick_next = tick_reg - TICK_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (end_hit) begin
      done_next = 1'b1;
      tick_next = '0;
`ifdef NOTE_SEQ_LOOP_EN
      index_next = '0;
      state_next = FETCH;
`else
      state_next = DONE;
`endif
    end

    // Abort overrides everything decided above, including an end marker.
    if (stop && state_reg != IDLE) begin
      state_next = IDLE;
      song_next  = song_reg;
      index_next = index_reg;
      tick_next  = '0;
      freq_next  = freq_reg;
      amp_next   = 8'd0;
      done_next  = 1'b0;
    end
  end

  assign outputFrequency = freq_reg;
  assign outputAmplitude = amp_reg;
  assign noteIndex       = index_reg;
  assign busy            = (state_reg != IDLE);
  assign songDone        = done_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed testbench for note_sequencer with default parameters.
module tb_note_sequencer;

  localparam logic [7:0] AMP = 8'd200;

  logic        CLK_32KHz = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [1:0]  songSelect;
  logic [13:0] outputFrequency;
  logic [7:0]  outputAmplitude;
  logic [5:0]  noteIndex;
  logic        busy;
  logic        songDone;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK_32KHz = ~CLK_32KHz;

  note_sequencer dut (
    .CLK_32KHz       (CLK_32KHz),
    .reset           (reset),
    .start           (start),
    .stop            (stop),
    .songSelect      (songSelect),
    .outputFrequency (outputFrequency),
    .outputAmplitude (outputAmplitude),
    .noteIndex       (noteIndex),
    .busy            (busy),
    .songDone        (songDone)
  );

  task automatic pulse_start(input logic [1:0] sel);
    start = 1'b1;
    songSelect = sel;
    @(negedge CLK_32KHz);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cycles, output logic seen);
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < limit) begin
      if (songDone === 1'b1) seen = 1'b1;
      else begin
        @(negedge CLK_32KHz);
        cycles++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge CLK_32KHz);
    n_cmp++; if (outputFrequency !== 14'd0) begin n_err++; $display("FAIL reset_freq: got %0d expected 0", outputFrequency); end
    n_cmp++; if (outputAmplitude !== 8'd0) begin n_err++; $display("FAIL reset_amp: got %0d expected 0", outputAmplitude); end
    n_cmp++; if (noteIndex !== 6'd0) begin n_err++; $display("FAIL reset_index: got %0d expected 0", noteIndex); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (songDone !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", songDone); end
    reset = 1'b0;
    @(negedge CLK_32KHz);
    $display("reset: outputs idle after reset");
  endtask

  task automatic test_song0();
    int hi, lo;
    pulse_start(2'd0);
    n_cmp++; if (outputAmplitude !== 8'd0 || busy !== 1'b1) begin n_err++; $display("FAIL song0_fetch: amp=%0d busy=%b expected amp=0 busy=1", outputAmplitude, busy); end
    @(negedge CLK_32KHz);
    n_cmp++; if (outputAmplitude !== AMP) begin n_err++; $display("FAIL song0_latency: amp=%0d expected %0d", outputAmplitude, AMP); end
    n_cmp++; if (outputFrequency !== 14'd440) begin n_err++; $display("FAIL song0_freq: got %0d expected 440", outputFrequency); end
    hi = 0;
    while (outputAmplitude === AMP && hi < 1000) begin hi++; @(negedge CLK_32KHz); end
    n_cmp++; if (hi != 64) begin n_err++; $display("FAIL song0_play_len: got %0d expected 64", hi); end
    lo = 0;
    while (outputAmplitude === 8'd0 && songDone !== 1'b1 && lo < 1000) begin lo++; @(negedge CLK_32KHz); end
    n_cmp++; if (lo != 321) begin n_err++; $display("FAIL song0_gap_len: got %0d expected 321", lo); end
    n_cmp++; if (songDone !== 1'b1 || noteIndex !== 6'd1 || outputFrequency !== 14'd440) begin n_err++; $display("FAIL song0_done: done=%b idx=%0d freq=%0d expected 1/1/440", songDone, noteIndex, outputFrequency); end
    @(negedge CLK_32KHz);
    n_cmp++; if (songDone !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL song0_idle: done=%b busy=%b expected 0/0", songDone, busy); end
    $display("song0: play %0d cycles, silent %0d cycles before songDone", hi, lo);
  endtask

  task automatic test_rest();
    int bad, c;
    logic seen;
    pulse_start(2'd1);
    @(negedge CLK_32KHz);
    n_cmp++; if (outputFrequency !== 14'd523 || outputAmplitude !== AMP) begin n_err++; $display("FAIL rest_note0: freq=%0d amp=%0d expected 523/200", outputFrequency, outputAmplitude); end
    repeat (353) @(negedge CLK_32KHz);
    n_cmp++; if (noteIndex !== 6'd1 || outputFrequency !== 14'd0 || outputAmplitude !== 8'd0 || busy !== 1'b1) begin n_err++; $display("FAIL rest_entry: idx=%0d freq=%0d amp=%0d busy=%b expected 1/0/0/1", noteIndex, outputFrequency, outputAmplitude, busy); end
    bad = 0;
    for (int i = 0; i < 352; i++) begin
      @(negedge CLK_32KHz);
      if (outputAmplitude !== 8'd0 || outputFrequency !== 14'd0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rest_silent: got %0d sounding cycles expected 0", bad); end
    @(negedge CLK_32KHz);
    n_cmp++; if (noteIndex !== 6'd2 || outputFrequency !== 14'd659 || outputAmplitude !== AMP) begin n_err++; $display("FAIL rest_note2: idx=%0d freq=%0d amp=%0d expected 2/659/200", noteIndex, outputFrequency, outputAmplitude); end
    wait_done(2000, c, seen);
    n_cmp++; if (!seen || noteIndex !== 6'd3) begin n_err++; $display("FAIL rest_done: seen=%b idx=%0d expected 1/3", seen, noteIndex); end
    repeat (2) @(negedge CLK_32KHz);
    $display("rest: rest entry silent, next note at index 2");
  endtask

  task automatic test_stop();
    int bad;
    pulse_start(2'd0);
    @(negedge CLK_32KHz);
    repeat (9) @(negedge CLK_32KHz);
    stop = 1'b1;
    start = 1'b1;
    songSelect = 2'd1;
    @(negedge CLK_32KHz);
    stop = 1'b0;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0 || outputAmplitude !== 8'd0) begin n_err++; $display("FAIL stop_idle: busy=%b amp=%0d expected 0/0", busy, outputAmplitude); end
    n_cmp++; if (outputFrequency !== 14'd440 || songDone !== 1'b0) begin n_err++; $display("FAIL stop_hold: freq=%0d done=%b expected 440/0", outputFrequency, songDone); end
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK_32KHz);
      if (songDone !== 1'b0 || busy !== 1'b0 || outputAmplitude !== 8'd0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stop_quiet: got %0d active cycles expected 0", bad); end
    $display("stop: playback aborted in PLAY cycle 10");
  endtask

  task automatic test_start_while_busy();
    int c;
    logic seen;
    pulse_start(2'd3);
    @(negedge CLK_32KHz);
    start = 1'b1;
    songSelect = 2'd0;
    @(negedge CLK_32KHz);
    start = 1'b0;
    n_cmp++; if (outputFrequency !== 14'd330 || noteIndex !== 6'd0) begin n_err++; $display("FAIL busy_start_ignored: freq=%0d idx=%0d expected 330/0", outputFrequency, noteIndex); end
    repeat (352) @(negedge CLK_32KHz);
    n_cmp++; if (outputFrequency !== 14'd392 || noteIndex !== 6'd1 || outputAmplitude !== AMP) begin n_err++; $display("FAIL busy_note1: freq=%0d idx=%0d amp=%0d expected 392/1/200", outputFrequency, noteIndex, outputAmplitude); end
    wait_done(2000, c, seen);
    n_cmp++; if (!seen || noteIndex !== 6'd2) begin n_err++; $display("FAIL busy_done: seen=%b idx=%0d expected 1/2", seen, noteIndex); end
    repeat (2) @(negedge CLK_32KHz);
    $display("start_while_busy: second start ignored");
  endtask

  task automatic test_full_song();
    int n, rises;
    logic [7:0] prev;
    pulse_start(2'd2);
    n = 0;
    rises = 0;
    prev = outputAmplitude;
    while (songDone !== 1'b1 && n < 30000) begin
      @(negedge CLK_32KHz);
      n++;
      if (prev === 8'd0 && outputAmplitude === AMP) rises++;
      prev = outputAmplitude;
    end
    n_cmp++; if (n != 22592) begin n_err++; $display("FAIL full_length: got %0d cycles expected 22592", n); end
    n_cmp++; if (rises != 64) begin n_err++; $display("FAIL full_notes: got %0d notes expected 64", rises); end
    n_cmp++; if (noteIndex !== 6'd63 || outputFrequency !== 14'd830) begin n_err++; $display("FAIL full_end: idx=%0d freq=%0d expected 63/830", noteIndex, outputFrequency); end
    @(negedge CLK_32KHz);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_idle: busy=%b expected 0", busy); end
    $display("full_song: 64 entries in %0d cycles", n);
  endtask

  task automatic test_loop();
    int c;
    logic seen;
    pulse_start(2'd3);
    wait_done(2000, c, seen);
    n_cmp++; if (!seen || c != 707) begin n_err++; $display("FAIL loop_first: seen=%b cycles=%0d expected 1/707", seen, c); end
    n_cmp++; if (noteIndex !== 6'd0 || busy !== 1'b1) begin n_err++; $display("FAIL loop_restart: idx=%0d busy=%b expected 0/1", noteIndex, busy); end
    @(negedge CLK_32KHz);
    wait_done(2000, c, seen);
    n_cmp++; if (!seen || c != 706 || busy !== 1'b1) begin n_err++; $display("FAIL loop_second: seen=%b cycles=%0d busy=%b expected 1/706/1", seen, c, busy); end
    stop = 1'b1;
    @(negedge CLK_32KHz);
    stop = 1'b0;
    n_cmp++; if (busy !== 1'b0 || outputAmplitude !== 8'd0) begin n_err++; $display("FAIL loop_stop: busy=%b amp=%0d expected 0/0", busy, outputAmplitude); end
    $display("loop: songDone every pass until stop");
  endtask

  task automatic test_reset_mid_gap();
    int bad;
    pulse_start(2'd0);
    @(negedge CLK_32KHz);
    repeat (100) @(negedge CLK_32KHz);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (outputFrequency !== 14'd0 || outputAmplitude !== 8'd0) begin n_err++; $display("FAIL async_reset_out: freq=%0d amp=%0d expected 0/0", outputFrequency, outputAmplitude); end
    n_cmp++; if (noteIndex !== 6'd0 || busy !== 1'b0 || songDone !== 1'b0) begin n_err++; $display("FAIL async_reset_state: idx=%0d busy=%b done=%b expected 0/0/0", noteIndex, busy, songDone); end
    @(negedge CLK_32KHz);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK_32KHz);
      if (songDone !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL reset_abandon: got %0d active cycles expected 0", bad); end
    pulse_start(2'd0);
    @(negedge CLK_32KHz);
    n_cmp++; if (outputFrequency !== 14'd440 || outputAmplitude !== AMP || noteIndex !== 6'd0) begin n_err++; $display("FAIL reset_replay: freq=%0d amp=%0d idx=%0d expected 440/200/0", outputFrequency, outputAmplitude, noteIndex); end
    stop = 1'b1;
    @(negedge CLK_32KHz);
    stop = 1'b0;
    $display("reset_mid_gap: outputs cleared immediately, replay from entry 0");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    songSelect = 2'd0;
    test_reset();
`ifdef NOTE_SEQ_LOOP_EN
    test_loop();
`else
    test_song0();
    test_rest();
    test_start_while_busy();
    test_full_song();
`endif
    test_stop();
    test_reset_mid_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter AMP_ON, default 8'd200, amplitude driven while a note sounds.
REQ-002 Parameter TICKS_PER_UNIT, default 32, CLK_32KHz cycles per duration unit (1 ms).
REQ-003 Parameter GAP_TICKS, default 320, silent cycles inserted between consecutive notes.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 CLK_32KHz  in  1  sole clock, 32 kHz sample clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 start  in  1  single-cycle pulse, begin selected song from entry 0.
REQ-008 stop  in  1  single-cycle pulse, abort playback.
REQ-009 songSelect  in  2  song number, sampled only on accepted start.
REQ-010 outputFrequency  out  14  frequency (Hz) to signal generator inputFrequency.
REQ-011 outputAmplitude  out  8  amplitude to signal generator inputAmplitude.
REQ-012 noteIndex  out  6  current song entry.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 songDone  out  1  single-cycle pulse on reaching song end.

Function
REQ-015 States SHALL be IDLE, FETCH, PLAY, GAP, DONE.
REQ-016 Song entry SHALL be {freq[13:0], dur[9:0]}; 4 songs x 64 entries; ROM read latency 1 cycle.
REQ-017 IDLE: start (without stop) SHALL latch songSelect, clear noteIndex, go FETCH; start while busy SHALL be ignored.
REQ-018 FETCH SHALL last exactly 1 cycle; dur==0 SHALL be the end marker -> DONE; otherwise load freq into outputFrequency and go PLAY.
REQ-019 PLAY SHALL last dur*TICKS_PER_UNIT cycles (26-bit tick arithmetic, no overflow); outputAmplitude = AMP_ON, or 0 when freq==0 (rest).
REQ-020 GAP SHALL last GAP_TICKS cycles with outputAmplitude 0 and outputFrequency held, then increment noteIndex and go FETCH.
REQ-021 Entry 63 completing GAP SHALL be treated as end marker -> DONE (noteIndex never wraps mid-song).
REQ-022 DONE SHALL pulse songDone for one cycle, amplitude 0, then go IDLE.
REQ-023 stop SHALL win over start in the same cycle; stop in any busy state SHALL force IDLE next cycle with outputAmplitude 0, outputFrequency held, no songDone.
REQ-024 Latency start -> first nonzero outputAmplitude SHALL be 3 cycles (IDLE->FETCH->PLAY registered output).

Reset
REQ-025 reset SHALL force IDLE, outputFrequency 0, outputAmplitude 0, noteIndex 0, busy 0, songDone 0, all counters 0, independent of clock.
REQ-026 reset asserted mid-song SHALL abandon the song; no songDone on release.

Configuration
REQ-027 Macro NOTE_SEQ_LOOP_EN defined: end marker SHALL pulse songDone, clear noteIndex and go FETCH (busy stays high, loops until stop).
REQ-028 Macro NOTE_SEQ_LOOP_EN undefined: end marker SHALL go DONE then IDLE per REQ-022.

Structure
REQ-029 Package musicbox_pkg SHALL hold note_entry_t struct, seq_state_t enum, SONG_COUNT=4, SONG_LEN=64, FREQ_W=14, DUR_W=10.
REQ-030 Sub-module note_rom (registered read, address {song, index}) SHALL hold song tables; sequencer holds FSM and counters only.

Verification
REQ-031 Song 0 = {440 Hz, dur 2},{end}: start -> amplitude 200 for exactly 64 cycles at freq 440, 0 for 320, songDone pulse 1 cycle, busy low after.
REQ-032 Rest entry {0, dur 1}: outputAmplitude stays 0 for 32 cycles, outputFrequency 0, noteIndex advances.
REQ-033 stop in PLAY cycle 10 with simultaneous start: IDLE next cycle, amplitude 0, no songDone, freq held.
REQ-034 Full 64-entry song, no end marker: DONE after entry 63 GAP, noteIndex stays 63 at songDone.
REQ-035 NOTE_SEQ_LOOP_EN defined, 2-note song: songDone pulses every pass, noteIndex returns to 0, busy never drops until stop.
REQ-036 reset asserted mid-GAP (asynchronous, between edges): all outputs 0 immediately; start after release replays from entry 0.
